// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: one-hot registered grant, per-requester
// quota of max(weight,1) consecutive cycles before priority rotates.
module wrr_arbiter #(
    parameter int N   = 4,
    parameter int WW  = 4,
    parameter int IDW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] weight,
    output logic [N-1:0]    gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_vld
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [WW-1:0]  cnt;

    logic [IDW-1:0] pick;
    logic [IDW-1:0] pick_nxt;
    logic [WW-1:0]  pick_w;
    logic [WW-1:0]  pick_cnt;
    logic [N-1:0]   pick_oh;
    logic           any;
    logic           do_grant;
    logic           do_idle;
    logic           do_dec;

    // First requester at or after ptr, by circular distance.
    always_comb begin
        int best;
        int d;
        best = N;
        d    = 0;
        pick = ptr;
        for (int j = 0; j < N; j++) begin
            if (j >= int'(ptr))
                d = j - int'(ptr);
            else
                d = j + N - int'(ptr);
            if (req[j] && d < best) begin
                best = d;
                pick = IDW'(j);
            end
        end
    end

    always_comb begin
        any      = |req;
        pick_w   = weight[int'(pick)*WW +: WW];
        pick_cnt = (pick_w == '0) ? '0 : pick_w - WW'(1);
        pick_nxt = (pick == IDW'(N-1)) ? '0 : pick + 1'b1;
        pick_oh  = N'(1) << pick;
    end

    always_comb begin
        do_grant = 1'b0;
        do_idle  = 1'b0;
        do_dec   = 1'b0;
        if (en) begin
            unique case (state)
                IDLE: do_grant = any;
                GRANT: begin
                    if (!req[gnt_id]) begin
                        do_grant = any;
                        do_idle  = !any;
                    end else if (cnt == '0) begin
                        do_grant = 1'b1;
                    end else begin
                        do_dec = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
        end else if (do_grant) begin
            state   <= GRANT;
            ptr     <= pick_nxt;
            cnt     <= pick_cnt;
            gnt     <= pick_oh;
            gnt_id  <= pick;
            gnt_vld <= 1'b1;
        end else if (do_idle) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_vld <= 1'b0;
        end else if (do_dec) begin
            cnt <= cnt - WW'(1);
        end
    end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: directed scenarios plus
// randomized traffic against a cycle-count reference model.
module tb_wrr_arbiter;

    localparam int N   = 4;
    localparam int WW  = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*WW-1:0] weight = '0;
    logic [N-1:0]    gnt;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_vld;

    int n_cmp = 0;
    int n_fail = 0;

    wrr_arbiter #(.N(N), .WW(WW), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .weight(weight), .gnt(gnt), .gnt_id(gnt_id),
        .gnt_vld(gnt_vld)
    );

    always #5 clk = ~clk;

    // Reference model: holder, cycles held so far, quota, next start.
    int m_hold = -1;
    int m_used = 0;
    int m_quota = 1;
    int m_ptr = 0;

    function automatic int m_sel(int start, logic [N-1:0] r);
        for (int k = 0; k < N; k++)
            if (r[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    function automatic int wgt(int j);
        int w;
        w = int'(weight[j*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    task automatic m_grant(int j);
        m_hold  = j;
        m_used  = 1;
        m_quota = wgt(j);
        m_ptr   = (j + 1) % N;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hold = -1; m_used = 0; m_quota = 1; m_ptr = 0;
        end else if (en) begin
            if (m_hold < 0) begin
                if (req != 0) m_grant(m_sel(m_ptr, req));
            end else if (!req[m_hold]) begin
                if (req != 0) m_grant(m_sel((m_hold + 1) % N, req));
                else m_hold = -1;
            end else if (m_used < m_quota) begin
                m_used++;
            end else begin
                m_grant(m_sel((m_hold + 1) % N, req));
            end
        end
    end

    function automatic logic [N-1:0] m_gnt();
        return (m_hold < 0) ? '0 : N'(1) << m_hold;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b1; req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; weight = {4'd1, 4'd1, 4'd1, 4'd1};
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: gnt=%b vld=%b want 0000/0", gnt, gnt_vld);
            end
        end
        @(negedge clk);
        rst = 1'b0; req = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_id !== 2'd0) begin
                n_fail++;
                $display("FAIL idle: gnt=%b vld=%b id=%0d want 0000/0/0", gnt, gnt_vld, gnt_id);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            req = N'(1) << i;
            @(posedge clk); #1;
            n_cmp++;
            if (gnt !== (N'(1) << i) || gnt_id !== IDW'(i) || gnt_vld !== 1'b1) begin
                n_fail++;
                $display("FAIL single_%0d: gnt=%b id=%0d want %b/%0d", i, gnt, gnt_id, N'(1) << i, i);
            end
        end
    endtask

    task automatic test_weighted();
        int e;
        do_reset();
        weight = {4'd1, 4'd2, 4'd3, 4'd4};
        @(negedge clk);
        req = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            e = (c % 10 < 4) ? 0 : (c % 10 < 7) ? 1 : (c % 10 < 9) ? 2 : 3;
            n_cmp++;
            if (gnt !== (N'(1) << e) || gnt_id !== IDW'(e) || gnt_vld !== 1'b1) begin
                n_fail++;
                $display("FAIL weighted c%0d: gnt=%b id=%0d want %b/%0d", c, gnt, gnt_id, N'(1) << e, e);
            end
        end
    endtask

    task automatic test_early_release();
        logic [N-1:0] exp [4];
        exp = '{4'b0001, 4'b0010, 4'b0010, 4'b0100};
        do_reset();
        weight = {4'd1, 4'd1, 4'd5, 4'd0};
        @(negedge clk);
        req = 4'b0111;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                @(negedge clk);
                req = 4'b0101;
            end
            @(posedge clk); #1;
            n_cmp++;
            if (gnt !== exp[c]) begin
                n_fail++;
                $display("FAIL early_release c%0d: gnt=%b want %b", c, gnt, exp[c]);
            end
        end
    endtask

    task automatic test_sole_en();
        do_reset();
        weight = {4'd1, 4'd2, 4'd1, 4'd1};
        @(negedge clk);
        req = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
                n_fail++;
                $display("FAIL sole c%0d: gnt=%b id=%0d want 0100/2", c, gnt, gnt_id);
            end
        end
        @(negedge clk);
        en = 1'b0; req = 4'b1100;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (gnt !== 4'b0100 || gnt_id !== 2'd2 || gnt_vld !== 1'b1) begin
                n_fail++;
                $display("FAIL freeze c%0d: gnt=%b id=%0d want 0100/2", c, gnt, gnt_id);
            end
        end
        @(negedge clk);
        en = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL resume_hold: gnt=%b want 0100", gnt);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            n_fail++;
            $display("FAIL resume_rotate: gnt=%b id=%0d want 1000/3", gnt, gnt_id);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        weight = {4'd3, 4'd3, 4'd3, 4'd3};
        @(negedge clk);
        req = 4'b0010;
        @(posedge clk); #1;
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL pre_reset: gnt=%b want 0010", gnt);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: gnt=%b vld=%b want 0000/0", gnt, gnt_vld);
        end
        @(negedge clk);
        rst = 1'b0; req = 4'b1111;
        @(posedge clk); #1;
        n_cmp++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL after_reset: gnt=%b id=%0d want 0001/0", gnt, gnt_id);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] e;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req = 4'b1111;
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) weight = ($urandom() & 16'hffff);
            @(posedge clk); #1;
            e = m_gnt();
            n_cmp++;
            if (gnt !== e || gnt_vld !== (e != 0) || (e != 0 && gnt_id !== IDW'(m_hold))) begin
                n_fail++;
                $display("FAIL random c%0d: gnt=%b vld=%b id=%0d want %b/%0d", c, gnt, gnt_vld, gnt_id, e, m_hold);
            end
        end
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_weighted();
        test_early_release();
        test_sole_en();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
